// File: rtl/enc_bin2onehot_stream.sv
// Streaming binary-to-one-hot encoder with a registered output stage and skid slot.
// Optional saturating out-of-range counter on err_cnt, enabled by ENC_B2OH_ERRCNT_EN.
module enc_bin2onehot_stream #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_N = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_N-1:0]  out,
  output logic              out_err
`ifdef ENC_B2OH_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CODE_SP = 1 << IN_W;

  // Reject illegal parameterisations at elaboration
  if (IN_W < 1 || IN_W > 8) begin : g_bad_in_w
    $error("enc_bin2onehot_stream: IN_W must be in 1..8");
  end
  if (OUT_N < 1 || OUT_N > CODE_SP) begin : g_bad_out_n
    $error("enc_bin2onehot_stream: OUT_N must be in 1..2**IN_W");
  end

  logic              fire_c;
  logic [OUT_N-1:0]  in_word_c;
  logic              in_err_c;

  logic              skid_valid;
  logic [OUT_N-1:0]  skid_word;
  logic              skid_err;

  logic              main_valid_d;
  logic              skid_valid_d;
  logic              main_load_c;
  logic              main_from_skid_c;
  logic              skid_load_c;

  assign fire_c = in_valid & in_ready;

  // Encode the incoming code; out-of-range codes produce an all-zero word
  always_comb begin
    in_word_c = '0;
    for (int k = 0; k < int'(OUT_N); k++) begin
      in_word_c[k] = (in == IN_W'(k));
    end
  end

  assign in_err_c = (32'(in) >= 32'(OUT_N));

  // Next-state for the two-entry store; MAIN drains whenever it is empty or accepted
  always_comb begin
    main_valid_d     = out_valid;
    skid_valid_d     = skid_valid;
    main_load_c      = 1'b0;
    main_from_skid_c = 1'b0;
    skid_load_c      = 1'b0;
    if (!out_valid || out_ready) begin
      if (skid_valid) begin
        main_from_skid_c = 1'b1;
        main_valid_d     = 1'b1;
        skid_valid_d     = 1'b0;
      end else if (fire_c) begin
        main_load_c  = 1'b1;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (fire_c) begin
      skid_load_c  = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  // Control state; in_ready tracks the registered skid occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      out_valid  <= main_valid_d;
      skid_valid <= skid_valid_d;
      in_ready   <= ~skid_valid_d;
    end
  end

  // Output data only changes on a load, so it holds while idle or stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out     <= '0;
      out_err <= 1'b0;
    end else if (main_from_skid_c) begin
      out     <= skid_word;
      out_err <= skid_err;
    end else if (main_load_c) begin
      out     <= in_word_c;
      out_err <= in_err_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_word <= '0;
      skid_err  <= 1'b0;
    end else if (skid_load_c) begin
      skid_word <= in_word_c;
      skid_err  <= in_err_c;
    end
  end

`ifdef ENC_B2OH_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating count of accepted out-of-range codes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (fire_c && in_err_c && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_enc_bin2onehot_stream.sv
// Directed and randomised checks for enc_bin2onehot_stream (4/15 and 3/8 instances).
module tb_enc_bin2onehot_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          failures = 0;

  // Instance A: IN_W=4, OUT_N=15
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0]  din;
  logic [14:0] dout;
`ifdef ENC_B2OH_ERRCNT_EN
  logic [7:0]  err_cnt;
  logic [7:0]  err_cnt2;
`endif

  // Instance B: IN_W=3, OUT_N=8
  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_err2;
  logic [2:0]  din2;
  logic [7:0]  dout2;

  always #5 clk = ~clk;

  enc_bin2onehot_stream #(.IN_W(4), .OUT_N(15)) dut (
    .clk(clk), .rst(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in(din),
    .out_valid(out_valid), .out_ready(out_ready), .out(dout), .out_err(out_err)
`ifdef ENC_B2OH_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  enc_bin2onehot_stream #(.IN_W(3), .OUT_N(8)) dut2 (
    .clk(clk), .rst(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in(din2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out(dout2), .out_err(out_err2)
`ifdef ENC_B2OH_ERRCNT_EN
    , .err_cnt(err_cnt2)
`endif
  );

  logic [14:0] exp_tbl [15] = '{15'h0001, 15'h0002, 15'h0004, 15'h0008, 15'h0010,
                                15'h0020, 15'h0040, 15'h0080, 15'h0100, 15'h0200,
                                15'h0400, 15'h0800, 15'h1000, 15'h2000, 15'h4000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; din = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; din2 = '0; out_ready2 = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || dout !== 15'h0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b ready=%b out=%h err=%b want 0 0 0000 0",
               out_valid, in_ready, dout, out_err);
    end
`ifdef ENC_B2OH_ERRCNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
    end
`endif
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1;
    din = 4'd0;
    for (int c = 0; c < 15; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== exp_tbl[c] || out_err !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_code%0d: valid=%b out=%h err=%b ready=%b want 1 %h 0 1",
                 c, out_valid, dout, out_err, in_ready, exp_tbl[c]);
      end
      if (c < 14) din = 4'(c + 1);
      else in_valid = 1'b0;
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || dout !== 15'h4000) begin
      failures++;
      $display("FAIL b2b_idle_hold: valid=%b out=%h want 0 4000", out_valid, dout);
    end
  endtask

  task automatic test_out_of_range();
`ifdef ENC_B2OH_ERRCNT_EN
    checks++;
    if (err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL err_cnt_before: got %0d want 0", err_cnt);
    end
`endif
    out_ready = 1'b1;
    in_valid = 1'b1;
    din = 4'd15;
    tick();
    checks++;
    if (out_valid !== 1'b1 || dout !== 15'h0000 || out_err !== 1'b1) begin
      failures++;
      $display("FAIL code15: valid=%b out=%h err=%b want 1 0000 1", out_valid, dout, out_err);
    end
`ifdef ENC_B2OH_ERRCNT_EN
    checks++;
    if (err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL err_cnt_inc: got %0d want 1", err_cnt);
    end
`endif
    din = 4'd2;
    tick();
    checks++;
    if (out_valid !== 1'b1 || dout !== 15'h0004 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL code2_after_err: valid=%b out=%h err=%b want 1 0004 0", out_valid, dout, out_err);
    end
`ifdef ENC_B2OH_ERRCNT_EN
    checks++;
    if (err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL err_cnt_hold: got %0d want 1", err_cnt);
    end
`endif
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1;
    din = 4'd3;
    tick();
    checks++;
    if (out_valid !== 1'b1 || dout !== 15'h0008 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first: valid=%b out=%h ready=%b want 1 0008 1", out_valid, dout, in_ready);
    end
    din = 4'd5;
    tick();
    checks++;
    if (dout !== 15'h0008 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_skid_full: out=%h ready=%b want 0008 0", dout, in_ready);
    end
    din = 4'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || dout !== 15'h0008 || out_err !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall%0d: valid=%b out=%h err=%b ready=%b want 1 0008 0 0",
                 i, out_valid, dout, out_err, in_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || dout !== 15'h0020 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain_skid: valid=%b out=%h ready=%b want 1 0020 1", out_valid, dout, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || dout !== 15'h0080) begin
      failures++;
      $display("FAIL bp_third: valid=%b out=%h want 1 0080", out_valid, dout);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || dout !== 15'h0080) begin
      failures++;
      $display("FAIL bp_empty: valid=%b out=%h want 0 0080", out_valid, dout);
    end
  endtask

  task automatic test_reset_mid_stream();
    out_ready = 1'b0;
    in_valid = 1'b1;
    din = 4'd3;
    tick();
    din = 4'd5;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || dout !== 15'h0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_assert: valid=%b ready=%b out=%h err=%b want 0 0 0000 0",
               out_valid, in_ready, dout, out_err);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_no_stale: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    in_valid = 1'b1;
    din = 4'd9;
    tick();
    checks++;
    if (out_valid !== 1'b1 || dout !== 15'h0200) begin
      failures++;
      $display("FAIL rst_mid_first_word: valid=%b out=%h want 1 0200", out_valid, dout);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_single: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    in_valid = 1'b1;
    din = 4'd15;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || dout !== 15'h0 || out_err !== 1'b1) begin
      failures++;
      $display("FAIL sat_last_word: valid=%b out=%h err=%b want 0 0000 1", out_valid, dout, out_err);
    end
`ifdef ENC_B2OH_ERRCNT_EN
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_err_cnt: got %0d want 255", err_cnt);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_err_cnt_hold: got %0d want 255", err_cnt);
    end
`endif
  endtask

  task automatic test_random_stream();
    logic [2:0] q[$];
    logic [7:0] prev_out;
    logic       hold;
    int         pushed;
    int         cycles;
    pushed = 0;
    cycles = 0;
    while (pushed < 10000 && cycles < 60000) begin
      in_valid2  = ($urandom_range(0, 3) != 0);
      din2       = 3'($urandom_range(0, 7));
      out_ready2 = ($urandom_range(0, 3) != 0);
      if (out_valid2 && out_ready2) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra_word: out=%h emitted with empty model", dout2);
        end else begin
          if (dout2 !== (8'(1) << q[0]) || out_err2 !== 1'b0) begin
            failures++;
            $display("FAIL rand_word: out=%h err=%b want %h 0", dout2, out_err2, 8'(1) << q[0]);
          end
          void'(q.pop_front());
        end
      end
      if (in_valid2 && in_ready2) begin
        q.push_back(din2);
        pushed++;
      end
      hold = out_valid2 && !out_ready2;
      prev_out = dout2;
      tick();
      cycles++;
      if (hold) begin
        checks++;
        if (out_valid2 !== 1'b1 || dout2 !== prev_out) begin
          failures++;
          $display("FAIL rand_hold: valid=%b out=%h want 1 %h", out_valid2, dout2, prev_out);
        end
      end
    end
    checks++;
    if (pushed < 10000) begin
      failures++;
      $display("FAIL rand_timeout: accepted %0d want 10000", pushed);
    end
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      if (out_valid2) begin
        checks++;
        if (dout2 !== (8'(1) << q[0])) begin
          failures++;
          $display("FAIL rand_drain_word: out=%h want %h", dout2, 8'(1) << q[0]);
        end
        void'(q.pop_front());
      end
      tick();
    end
    checks++;
    if (q.size() != 0 || out_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain_end: left=%0d valid=%b want 0 0", q.size(), out_valid2);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_stream();
    test_saturation();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
